// File: rtl/alien_fleet_pkg.sv
// alien_fleet_pkg
//   Shared definitions for the alien fleet controller: march state encoding,
//   the game-mode value that enables play, and the frame counter width.
//   No ports; imported by alien_fleet_ctrl and rr_fire_arbiter.
package alien_fleet_pkg;

  // Game mode value in which the fleet is allowed to advance.
  localparam logic [1:0] MODE_PLAY = 2'd2;

  // Width of the step counter, step period and shot-gap counter.
  localparam int CNT_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARCH_R,
    ST_DOWN_R,
    ST_MARCH_L,
    ST_DOWN_L,
    ST_CLEARED,
    ST_INVADED
  } fleet_state_t;

  // True in the four states where the fleet is actively marching.
  function automatic logic is_marching(input fleet_state_t s);
    return (s == ST_MARCH_R) || (s == ST_DOWN_R) ||
           (s == ST_MARCH_L) || (s == ST_DOWN_L);
  endfunction

endpackage

// File: rtl/alien_fleet_ctrl_rr_fire_arbiter.sv
// rr_fire_arbiter
//   Combinational round-robin arbiter for the single enemy-fire slot.
//   Starting at ptr, picks the first requesting index (wrapping modulo
//   NUM_REQ) and reports it as a one-hot grant plus the pointer to use next
//   (one past the winner).
// Ports
//   req       in   NUM_REQ  request vector (alive & ~laser_busy)
//   ptr       in   PTR_W    index searched first
//   en        in   1        arbitration enable; grant is all-zero when low
//   grant     out  NUM_REQ  one-hot winner (zero when none / disabled)
//   valid     out  1        a winner exists and en is high
//   next_ptr  out  PTR_W    (winner + 1) mod NUM_REQ, or ptr when no winner
module rr_fire_arbiter
  import alien_fleet_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int PTR_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid,
  output logic [PTR_W-1:0]   next_ptr
);

  // idx_arr[k] is the alien index examined k-th in the rotated order.
  logic [PTR_W-1:0]   idx_arr [NUM_REQ];
  logic [NUM_REQ-1:0] rot_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [PTR_W:0] sum;
      // ptr < NUM_REQ, so a single conditional subtract is a full modulo.
      assign sum          = {1'b0, ptr} + (PTR_W+1)'(gi);
      assign idx_arr[gi]  = (sum >= (PTR_W+1)'(NUM_REQ)) ?
                            PTR_W'(sum - (PTR_W+1)'(NUM_REQ)) : sum[PTR_W-1:0];
      assign rot_req[gi]  = req[idx_arr[gi]];
    end
  endgenerate

  always_comb begin
    grant    = '0;
    valid    = 1'b0;
    next_ptr = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && rot_req[k]) begin
        valid               = 1'b1;
        grant[idx_arr[k]]   = 1'b1;
        next_ptr            = (idx_arr[k] == PTR_W'(NUM_REQ - 1)) ? '0 : idx_arr[k] + 1'b1;
      end
    end
    if (!en) begin
      grant    = '0;
      valid    = 1'b0;
      next_ptr = ptr;
    end
  end

endmodule

// File: rtl/alien_fleet_ctrl.sv
// alien_fleet_ctrl
//   Fleet-level sequencer for NUM_ALIENS alien blocks. Drives the shared
//   march levels (right -> down -> left -> down -> ...), issues one step
//   strobe per step period, hands out the single enemy-fire slot round-robin
//   among alive aliens without a laser in flight, and flags wave-cleared or
//   invaded. Advances only on frame ticks while mode == play.
//
//   Build option: define ALIEN_FLEET_SPEEDUP_EN to shorten the step period
//   by SPEEDUP_PER_KILL frames per dead alien, floored at MIN_STEP_FRAMES.
//   Without it the period is fixed at STEP_FRAMES.
//
// Ports
//   clk           in   1           system clock
//   rst           in   1           synchronous active-high reset
//   mode          in   2           game mode; anything but play holds reset state
//   xCoord        in   10          VGA pixel x
//   yCoord        in   10          VGA pixel y
//   alive         in   NUM_ALIENS  per-alien alive
//   edge_hit      in   NUM_ALIENS  per-alien is_edge
//   laser_busy    in   NUM_ALIENS  per-alien laser in flight
//   at_bottom     in   1           some alien reached the barrier bottom
//   move_left     out  1           march-left level
//   move_right    out  1           march-right level
//   move_down     out  1           march-down level
//   step_strobe   out  1           one-clk pulse per march step
//   edge_clear    out  1           one-clk pulse: aliens clear is_edge
//   fire_grant    out  NUM_ALIENS  one-hot one-clk fire permission
//   wave_cleared  out  1           level: all aliens dead
//   invaded       out  1           level: fleet reached the bottom
module alien_fleet_ctrl
  import alien_fleet_pkg::*;
#(
  parameter int NUM_ALIENS       = 8,
  parameter int STEP_FRAMES      = 200,
  parameter int MIN_STEP_FRAMES  = 20,
  parameter int SPEEDUP_PER_KILL = 20,
  parameter int SHOT_GAP_FRAMES  = 120
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [9:0]            xCoord,
  input  logic [9:0]            yCoord,
  input  logic [NUM_ALIENS-1:0] alive,
  input  logic [NUM_ALIENS-1:0] edge_hit,
  input  logic [NUM_ALIENS-1:0] laser_busy,
  input  logic                  at_bottom,
  output logic                  move_left,
  output logic                  move_right,
  output logic                  move_down,
  output logic                  step_strobe,
  output logic                  edge_clear,
  output logic [NUM_ALIENS-1:0] fire_grant,
  output logic                  wave_cleared,
  output logic                  invaded
);

  localparam int PW = $clog2(NUM_ALIENS);

  // Elaboration-time guard on the legal parameter ranges.
  generate
    if (NUM_ALIENS < 2 || NUM_ALIENS > 16 ||
        STEP_FRAMES < 1 || STEP_FRAMES > 4095 ||
        MIN_STEP_FRAMES < 1 || MIN_STEP_FRAMES > STEP_FRAMES ||
        SPEEDUP_PER_KILL < 0 ||
        SHOT_GAP_FRAMES < 1 || SHOT_GAP_FRAMES > 4095) begin : g_bad_cfg
      $error("alien_fleet_ctrl: parameter out of range");
    end
  endgenerate

  // Anything other than play behaves exactly like reset.
  logic hold;
  assign hold = rst | (mode != MODE_PLAY);

  // Frame tick: rising edge of the (0,0) pixel, so one clk per frame even
  // if the pixel clock lingers on the origin for several system clocks.
  logic z, z_q_reg, tick;
  assign z    = (xCoord == 10'd0) && (yCoord == 10'd0);
  assign tick = z & ~z_q_reg;

  fleet_state_t          state_reg, state_next;
  logic [CNT_W-1:0]      step_cnt_reg, step_cnt_next;
  logic [CNT_W-1:0]      period_reg, period_next;
  logic [CNT_W-1:0]      shot_cnt_reg, shot_cnt_next;
  logic [PW-1:0]         rr_ptr_reg, rr_ptr_next;
  logic                  step_strobe_reg, step_strobe_next;
  logic                  edge_clear_reg, edge_clear_next;
  logic [NUM_ALIENS-1:0] fire_grant_reg, fire_grant_next;

  // Step period that will be latched at the next step / IDLE exit.
  logic [CNT_W-1:0] period_calc;

`ifdef ALIEN_FLEET_SPEEDUP_EN
  localparam int DW = $clog2(NUM_ALIENS + 1);
  logic [DW-1:0] dead_cnt;
  logic [31:0]   kill_red;
  logic [CNT_W-1:0] speed_diff;

  always_comb begin
    dead_cnt = '0;
    for (int i = 0; i < NUM_ALIENS; i++) begin
      if (!alive[i]) dead_cnt = dead_cnt + 1'b1;
    end
  end

  assign kill_red    = 32'(SPEEDUP_PER_KILL) * 32'(dead_cnt);
  // Saturating subtract: heavy losses bottom out at zero before the floor.
  assign speed_diff  = (32'(STEP_FRAMES) > kill_red) ?
                       CNT_W'(32'(STEP_FRAMES) - kill_red) : '0;
  assign period_calc = (speed_diff < CNT_W'(MIN_STEP_FRAMES)) ?
                       CNT_W'(MIN_STEP_FRAMES) : speed_diff;
`else
  assign period_calc = CNT_W'(STEP_FRAMES);
`endif

  logic edge_any, step_due, shot_ready;
  assign edge_any = |(edge_hit & alive);
  assign step_due = (step_cnt_reg >= period_reg - CNT_W'(1));
  // The counter reaching its cap on this tick releases a shot, so grants
  // are spaced exactly SHOT_GAP_FRAMES ticks apart when someone can fire.
  // With nobody eligible it parks at the cap and retries every tick.
  assign shot_ready = (shot_cnt_reg >= CNT_W'(SHOT_GAP_FRAMES - 1));

  logic [NUM_ALIENS-1:0] arb_grant;
  logic                  arb_valid;
  logic [PW-1:0]         arb_next_ptr;

  rr_fire_arbiter #(
    .NUM_REQ (NUM_ALIENS),
    .PTR_W   (PW)
  ) u_arb (
    .req      (alive & ~laser_busy),
    .ptr      (rr_ptr_reg),
    .en       (tick & shot_ready & is_marching(state_reg)),
    .grant    (arb_grant),
    .valid    (arb_valid),
    .next_ptr (arb_next_ptr)
  );

  always_ff @(posedge clk) begin
    if (hold) begin
      state_reg       <= ST_IDLE;
      z_q_reg         <= 1'b0;
      step_cnt_reg    <= '0;
      period_reg      <= '0;
      shot_cnt_reg    <= '0;
      rr_ptr_reg      <= '0;
      step_strobe_reg <= 1'b0;
      edge_clear_reg  <= 1'b0;
      fire_grant_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      z_q_reg         <= z;
      step_cnt_reg    <= step_cnt_next;
      period_reg      <= period_next;
      shot_cnt_reg    <= shot_cnt_next;
      rr_ptr_reg      <= rr_ptr_next;
      step_strobe_reg <= step_strobe_next;
      edge_clear_reg  <= edge_clear_next;
      fire_grant_reg  <= fire_grant_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    step_cnt_next    = step_cnt_reg;
    period_next      = period_reg;
    shot_cnt_next    = shot_cnt_reg;
    rr_ptr_next      = rr_ptr_reg;
    step_strobe_next = 1'b0;
    edge_clear_next  = 1'b0;
    fire_grant_next  = '0;

    case (state_reg)
      ST_IDLE: begin
        if (tick) begin
          state_next    = ST_MARCH_R;
          period_next   = period_calc;
          step_cnt_next = '0;
          shot_cnt_next = '0;
        end
      end

      ST_MARCH_R, ST_DOWN_R, ST_MARCH_L, ST_DOWN_L: begin
        if (tick) begin
          if (step_due) begin
            step_cnt_next    = '0;
            step_strobe_next = 1'b1;
            period_next      = period_calc;
            case (state_reg)
              ST_MARCH_R: begin
                if (edge_any) begin
                  state_next      = ST_DOWN_R;
                  edge_clear_next = 1'b1;
                end
              end
              ST_DOWN_R:  state_next = ST_MARCH_L;
              ST_MARCH_L: begin
                if (edge_any) begin
                  state_next      = ST_DOWN_L;
                  edge_clear_next = 1'b1;
                end
              end
              ST_DOWN_L:  state_next = ST_MARCH_R;
              default:    state_next = state_reg;
            endcase
          end else begin
            step_cnt_next = step_cnt_reg + 1'b1;
          end

          if (shot_ready) begin
            if (arb_valid) begin
              fire_grant_next = arb_grant;
              shot_cnt_next   = '0;
              rr_ptr_next     = arb_next_ptr;
            end else begin
              shot_cnt_next   = CNT_W'(SHOT_GAP_FRAMES);
            end
          end else begin
            shot_cnt_next = shot_cnt_reg + 1'b1;
          end
        end

        // End of wave overrides any step or shot decided this clk.
        if (alive == '0) begin
          state_next       = ST_CLEARED;
          step_strobe_next = 1'b0;
          edge_clear_next  = 1'b0;
          fire_grant_next  = '0;
        end else if (at_bottom) begin
          state_next       = ST_INVADED;
          step_strobe_next = 1'b0;
          edge_clear_next  = 1'b0;
          fire_grant_next  = '0;
        end
      end

      // CLEARED / INVADED are sticky until hold.
      default: state_next = state_reg;
    endcase
  end

  assign move_right   = (state_reg == ST_MARCH_R);
  assign move_left    = (state_reg == ST_MARCH_L);
  assign move_down    = (state_reg == ST_DOWN_R) || (state_reg == ST_DOWN_L);
  assign wave_cleared = (state_reg == ST_CLEARED);
  assign invaded      = (state_reg == ST_INVADED);
  assign step_strobe  = step_strobe_reg;
  assign edge_clear   = edge_clear_reg;
  assign fire_grant   = fire_grant_reg;

endmodule
